// File: rtl/pipe_barrel_shift.sv
// Pipelined barrel shifter (LSL/LSR/ASR/ROR) with valid/ready handshake; one stage per shift-amount bit.
// Define PBS_ROTATE_EN to build rotate-right for op 11; otherwise op 11 behaves as LSR.
module pipe_barrel_shift #(
    parameter int N = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [(2**N)-1:0]  in_x,
    input  logic [N-1:0]       in_shift,
    input  logic [1:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [(2**N)-1:0]  out_y,
    output logic               out_zero
);

    localparam int W        = 2**N;
    localparam int REM_BITS = (N * (N - 1)) / 2;

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_ASR = 2'b10;
`ifdef PBS_ROTATE_EN
    localparam logic [1:0] OP_ROR = 2'b11;
`endif

    // Bit offset of stage k's remaining-shift field in the packed rem_q vector.
    function automatic int rem_off(input int k);
        int s;
        s = 0;
        for (int j = 0; j < k; j++) begin
            s = s + (N - 1 - j);
        end
        return s;
    endfunction

    function automatic logic [W-1:0] shift_stage(
        input logic [W-1:0] d,
        input logic         en,
        input logic [1:0]   op,
        input int           amt
    );
        logic [W-1:0] r;
        r = d;
        if (en) begin
            case (op)
                OP_LSL:  r = d << amt;
                OP_ASR:  r = $signed(d) >>> amt;
`ifdef PBS_ROTATE_EN
                OP_ROR:  r = (d >> amt) | (d << (W - amt));
`endif
                default: r = d >> amt;
            endcase
        end
        return r;
    endfunction

    logic [N-1:0]          v_q;
    logic [N-1:0]          v_d;
    logic [N-1:0]          vin;
    logic [N-1:0]          ld;
    logic [N-1:0]          de;
    logic [N-1:0][W-1:0]   data_q;
    logic [N-1:0][W-1:0]   data_d;
    logic [N-2:0][1:0]     op_q;
    logic [N-2:0][1:0]     op_d;
    logic [REM_BITS-1:0]   rem_q;
    logic [REM_BITS-1:0]   rem_d;
    logic [REM_BITS-1:0]   rem_we;

    assign vin = {v_q[N-2:0], in_valid};
    assign de  = ld & vin;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_stage
            // A stage may load when any stage from here to the output is empty,
            // or when the output is being drained; this lets bubbles collapse.
            assign ld[gi]  = out_ready || !(&v_q[N-1:gi]);
            assign v_d[gi] = ld[gi] ? vin[gi] : v_q[gi];

            if (gi == 0) begin : g_first
                assign data_d[gi] = shift_stage(in_x, in_shift[0], in_op, 1);
            end else begin : g_rest
                localparam int PREV_OFF = rem_off(gi - 1);
                assign data_d[gi] = shift_stage(data_q[gi-1], rem_q[PREV_OFF],
                                                op_q[gi-1], 2**gi);
            end

            if (gi < N - 1) begin : g_fields
                localparam int OFF = rem_off(gi);
                localparam int RW  = N - 1 - gi;
                assign rem_we[OFF +: RW] = {RW{de[gi]}};
                if (gi == 0) begin : g_f0
                    assign op_d[gi]         = in_op;
                    assign rem_d[OFF +: RW] = in_shift[N-1:1];
                end else begin : g_fn
                    localparam int PREV_OFF = rem_off(gi - 1);
                    assign op_d[gi]         = op_q[gi-1];
                    assign rem_d[OFF +: RW] = rem_q[PREV_OFF + 1 +: RW];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q    <= '0;
            data_q <= '0;
            op_q   <= '0;
            rem_q  <= '0;
        end else begin
            v_q   <= v_d;
            rem_q <= (rem_q & ~rem_we) | (rem_d & rem_we);
            for (int k = 0; k < N; k++) begin
                if (de[k]) begin
                    data_q[k] <= data_d[k];
                end
            end
            for (int k = 0; k < N - 1; k++) begin
                if (de[k]) begin
                    op_q[k] <= op_d[k];
                end
            end
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = v_q[N-1];
    assign out_y     = data_q[N-1];
    assign out_zero  = v_q[N-1] && (data_q[N-1] == '0);

endmodule
